// File: rtl/hm01b0_pkg.sv
// hm01b0_pkg
//   Shared definitions for the HM01B0 parallel camera receiver.
//   - Default sensor geometry (active pixels per line, active lines per frame).
//   - Capture FSM state encoding, kept as plain 2-bit constants so the
//     state can be exported on a debug port and compared directly.
//   - Width of one tagged pixel tuple {data, x, y, sof, eof} as stored in
//     the output FIFO.
package hm01b0_pkg;

   localparam int unsigned HM01B0_WIDTH  = 320;
   localparam int unsigned HM01B0_HEIGHT = 240;
   localparam int unsigned HM01B0_PIX_W  = 8;

   // Capture FSM encoding.
   localparam logic [1:0] ST_WAIT_IDLE = 2'd0;  // waiting for vsync low
   localparam logic [1:0] ST_WAIT_VS   = 2'd1;  // waiting for vsync rise
   localparam logic [1:0] ST_IN_FRAME  = 2'd2;  // capturing active lines

   // Tuple layout, MSB first: data[7:0], x[x_w-1:0], y[y_w-1:0], sof, eof.
   function automatic int unsigned tuple_width(input int unsigned x_w,
                                               input int unsigned y_w);
      return HM01B0_PIX_W + x_w + y_w + 2;
   endfunction

   localparam int unsigned HM01B0_TUPLE_W = tuple_width(9, 8);

endpackage

// File: rtl/hm01b0_capture_fifo.sv
// hm01b0_capture_fifo
//   Synchronous first-word-fall-through FIFO: rdata always shows the oldest
//   entry while empty is low. A push while full is accepted only when a pop
//   happens in the same cycle; otherwise it is ignored (the caller decides
//   what that means). Pops while empty are ignored.
// Ports
//   clk    in   clock, posedge
//   rst_n  in   asynchronous active-low reset, empties the FIFO
//   push   in   write wdata this cycle
//   wdata  in   WIDTH-bit entry
//   pop    in   drop the head entry this cycle
//   rdata  out  head entry (valid while empty==0)
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
module hm01b0_capture_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign rdata = mem_q[rd_ptr_q];

   // A pop frees the slot the simultaneous push needs, so full+pop+push is lossless.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: it is only observed through non-empty reads.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/hm01b0_capture.sv
// hm01b0_capture
//   Receiver for the HM01B0 parallel camera bus. Registers the pins, tracks
//   pixel coordinates inside an enabled frame, checks line length and line
//   count, and streams tagged pixels {data,x,y,sof,eof} through a FWFT FIFO.
//
//   Output handshake: a tuple is transferred on a rising mclk edge where
//   out_valid and out_ready are both high. out_valid never depends on
//   out_ready; the tuple fields stay stable while out_valid is high and
//   out_ready is low. Tuple fields read as zero while out_valid is low.
// Ports
//   mclk, nreset            clock (posedge) and async active-low reset
//   capture_en              arms capture; only looked at on vsync rise
//   err_clear               pulse, clears the sticky error flags
//   pixdata, hsync, vsync   camera bus
//   out_valid/out_ready     tuple stream handshake
//   out_data/x/y/sof/eof    tuple fields
//   busy                    a frame is being captured
//   frame_count             error-free frames completed (wraps)
//   err_overflow/line/frame sticky error flags
//   dbg_state               capture FSM state (hm01b0_pkg encoding)
module hm01b0_capture
   import hm01b0_pkg::*;
#(
   parameter int unsigned WIDTH      = HM01B0_WIDTH,
   parameter int unsigned HEIGHT     = HM01B0_HEIGHT,
   parameter int unsigned X_W        = 9,
   parameter int unsigned Y_W        = 8,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic           mclk,
   input  logic           nreset,
   input  logic           capture_en,
   input  logic           err_clear,
   input  logic [7:0]     pixdata,
   input  logic           hsync,
   input  logic           vsync,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [7:0]     out_data,
   output logic [X_W-1:0] out_x,
   output logic [Y_W-1:0] out_y,
   output logic           out_sof,
   output logic           out_eof,
   output logic           busy,
   output logic [15:0]    frame_count,
   output logic           err_overflow,
   output logic           err_line,
   output logic           err_frame,
   output logic [1:0]     dbg_state
);

   localparam int unsigned TW = tuple_width(X_W, Y_W);

   localparam logic [X_W-1:0] X_END  = X_W'(WIDTH);
   localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
   localparam logic [Y_W-1:0] Y_END  = Y_W'(HEIGHT);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

   // Pin registers and the second stage used for edge detection.
   logic [7:0]     pd_q, pd_d;
   logic           hs_q, hs_d;
   logic           vs_q, vs_d;
   logic           hs_prev_q, hs_prev_d;
   logic           vs_prev_q, vs_prev_d;
   // Counts real samples since reset; edges are not trusted before it saturates.
   logic [1:0]     prime_q, prime_d;

   logic [1:0]     state_q, state_d;
   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic           frame_err_q, frame_err_d;
   logic [15:0]    frame_count_q, frame_count_d;
   logic           err_overflow_q, err_overflow_d;
   logic           err_line_q, err_line_d;
   logic           err_frame_q, err_frame_d;

   logic           pix;
   logic           vs_rise, vs_fall, hs_fall;
   logic           start;
   logic           active;
   logic [X_W-1:0] x_cur;
   logic [Y_W-1:0] y_cur;
   logic           frame_err_cur;
   logic           push;
   logic [TW-1:0]  tuple;
   logic           new_line_err;
   logic           new_frame_err;
   logic           new_ovf_err;
   logic           any_err;

   logic [TW-1:0]  fifo_rdata;
   logic           fifo_full;
   logic           fifo_empty;
   logic           pop;

   assign pix     = vs_q & hs_q;
   assign vs_rise = vs_q & ~vs_prev_q;
   assign vs_fall = ~vs_q & vs_prev_q;
   assign hs_fall = ~hs_q & hs_prev_q;

   assign out_valid = ~fifo_empty;
   assign pop       = out_valid & out_ready;

   // Frame starts on the vsync rise itself; that cycle already counts as in-frame.
   assign start  = (state_q == ST_WAIT_VS) && vs_rise && capture_en;
   assign active = (state_q == ST_IN_FRAME) || start;
   assign x_cur  = start ? '0 : x_q;
   assign y_cur  = start ? '0 : y_q;
   assign frame_err_cur = start ? 1'b0 : frame_err_q;

   always_comb begin
      pd_d          = pixdata;
      hs_d          = hsync;
      vs_d          = vsync;
      hs_prev_d     = hs_q;
      vs_prev_d     = vs_q;
      prime_d       = (prime_q == 2'd2) ? prime_q : prime_q + 2'd1;
      state_d       = state_q;
      x_d           = x_cur;
      y_d           = y_cur;
      push          = 1'b0;
      tuple         = '0;
      new_line_err  = 1'b0;
      new_frame_err = 1'b0;

      case (state_q)
         ST_WAIT_IDLE: if ((prime_q == 2'd2) && !vs_q) state_d = ST_WAIT_VS;
         ST_WAIT_VS:   if (start) state_d = ST_IN_FRAME;
         ST_IN_FRAME:  if (vs_fall) state_d = ST_WAIT_IDLE;
         default:      state_d = ST_WAIT_IDLE;
      endcase

      if (active) begin
         if (pix) begin
            if (y_cur == Y_END) begin
               // Line beyond the frame height: dropped.
               new_frame_err = 1'b1;
            end else if (x_cur == X_END) begin
               // Pixel beyond the line width: dropped.
               new_line_err = 1'b1;
            end else begin
               push  = 1'b1;
               tuple = {pd_q, x_cur, y_cur,
                        (x_cur == '0) && (y_cur == '0),
                        (x_cur == X_LAST) && (y_cur == Y_LAST)};
               x_d   = x_cur + 1'b1;
            end
         end

         // A line that was already open when vsync rose is blanking, not a frame line.
         if (hs_fall && !start) begin
            if (y_cur == Y_END) begin
               new_frame_err = 1'b1;
            end else begin
               if (x_cur != X_END) new_line_err = 1'b1;
               y_d = y_cur + 1'b1;
            end
            x_d = '0;
         end

         // y_d already includes a line closing in this same cycle.
         if (vs_fall && ((y_d != Y_END) || hs_q)) new_frame_err = 1'b1;
      end
   end

   assign new_ovf_err = push && fifo_full && !pop;
   assign any_err     = new_line_err | new_frame_err | new_ovf_err;

   always_comb begin
      frame_err_d    = frame_err_cur | any_err;
      frame_count_d  = frame_count_q;
      if (active && vs_fall && !(frame_err_cur || any_err)) begin
         frame_count_d = frame_count_q + 16'd1;
      end
      // A new error in the same cycle as err_clear leaves the flag set.
      err_overflow_d = (err_overflow_q & ~err_clear) | new_ovf_err;
      err_line_d     = (err_line_q & ~err_clear) | new_line_err;
      err_frame_d    = (err_frame_q & ~err_clear) | new_frame_err;
   end

   always_ff @(posedge mclk or negedge nreset) begin
      if (!nreset) begin
         pd_q           <= '0;
         hs_q           <= 1'b0;
         vs_q           <= 1'b0;
         hs_prev_q      <= 1'b0;
         vs_prev_q      <= 1'b0;
         prime_q        <= '0;
         state_q        <= ST_WAIT_IDLE;
         x_q            <= '0;
         y_q            <= '0;
         frame_err_q    <= 1'b0;
         frame_count_q  <= '0;
         err_overflow_q <= 1'b0;
         err_line_q     <= 1'b0;
         err_frame_q    <= 1'b0;
      end else begin
         pd_q           <= pd_d;
         hs_q           <= hs_d;
         vs_q           <= vs_d;
         hs_prev_q      <= hs_prev_d;
         vs_prev_q      <= vs_prev_d;
         prime_q        <= prime_d;
         state_q        <= state_d;
         x_q            <= x_d;
         y_q            <= y_d;
         frame_err_q    <= frame_err_d;
         frame_count_q  <= frame_count_d;
         err_overflow_q <= err_overflow_d;
         err_line_q     <= err_line_d;
         err_frame_q    <= err_frame_d;
      end
   end

   hm01b0_capture_fifo #(
      .WIDTH (TW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (mclk),
      .rst_n (nreset),
      .push  (push),
      .wdata (tuple),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Fields are forced to zero when nothing is valid so the idle bus is clean.
   assign out_data = out_valid ? fifo_rdata[TW-1 -: 8]     : '0;
   assign out_x    = out_valid ? fifo_rdata[2+Y_W +: X_W]  : '0;
   assign out_y    = out_valid ? fifo_rdata[2 +: Y_W]      : '0;
   assign out_sof  = out_valid ? fifo_rdata[1]             : 1'b0;
   assign out_eof  = out_valid ? fifo_rdata[0]             : 1'b0;

   assign busy         = (state_q == ST_IN_FRAME);
   assign frame_count  = frame_count_q;
   assign err_overflow = err_overflow_q;
   assign err_line     = err_line_q;
   assign err_frame    = err_frame_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_hm01b0_capture.sv
// Bench for hm01b0_capture with a reduced 24x4 frame geometry.
module tb_hm01b0_capture;
  import hm01b0_pkg::*;

  localparam int W  = 24;
  localparam int H  = 4;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int TW = 8 + XW + YW + 2;

  logic          mclk = 1'b0;
  logic          nreset;
  logic          capture_en;
  logic          err_clear;
  logic [7:0]    pixdata;
  logic          hsync;
  logic          vsync;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          out_sof;
  logic          out_eof;
  logic          busy;
  logic [15:0]   frame_count;
  logic          err_overflow;
  logic          err_line;
  logic          err_frame;
  logic [1:0]    dbg_state;

  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] mon_got;
  logic [TW-1:0] mon_exp;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            seed  = 0;

  hm01b0_capture #(
    .WIDTH (W),
    .HEIGHT(H),
    .X_W   (XW),
    .Y_W   (YW),
    .FIFO_DEPTH(16)
  ) dut (
    .mclk        (mclk),
    .nreset      (nreset),
    .capture_en  (capture_en),
    .err_clear   (err_clear),
    .pixdata     (pixdata),
    .hsync       (hsync),
    .vsync       (vsync),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .busy        (busy),
    .frame_count (frame_count),
    .err_overflow(err_overflow),
    .err_line    (err_line),
    .err_frame   (err_frame),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 mclk = ~mclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [7:0] pix_val(input int x, input int y);
    return 8'((x * 5 + y * 17 + seed * 29) & 255);
  endfunction

  function automatic logic [TW-1:0] pack(input int x, input int y);
    logic [7:0] d;
    d = pix_val(x, y);
    return {d, 9'(x), 8'(y), (x == 0 && y == 0), (x == W - 1 && y == H - 1)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cam_line(input int npix, input int y, input bit capt, input int keep);
    for (int x = 0; x < npix; x++) begin
      hsync   = 1'b1;
      pixdata = pix_val(x, y);
      if (capt && x < W && x < keep && y < H) exp_q.push_back(pack(x, y));
      tick(1);
    end
    hsync   = 1'b0;
    pixdata = 8'h00;
    tick(4);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
    check(name, exp_q.size(), 0);
  endtask

  task automatic cam_frame(input int nlines, input bit capt, input int long_row, input string name);
    vsync = 1'b1;
    tick(3);
    for (int y = 0; y < nlines; y++) cam_line((y == long_row) ? W + 1 : W, y, capt, W);
    vsync = 1'b0;
    tick(6);
    wait_drain(name);
  endtask

  task automatic pulse_clear;
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    tick(1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge mclk) begin
    if (nreset && out_valid && out_ready) begin
      mon_got = {out_data, out_x, out_y, out_sof, out_eof};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL tuple_unexpected: got data=%0h x=%0d y=%0d sof=%0b eof=%0b, none expected",
                 out_data, out_x, out_y, out_sof, out_eof);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_bad++;
          $display("FAIL tuple: got %0h expected %0h (x=%0d y=%0d)", mon_got, mon_exp, out_x, out_y);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    nreset     = 1'b0;
    capture_en = 1'b0;
    err_clear  = 1'b0;
    pixdata    = 8'h00;
    hsync      = 1'b0;
    vsync      = 1'b0;
    out_ready  = 1'b1;
    tick(3);

    // reset state
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_WAIT_IDLE);
    check("rst_count", frame_count, 0);
    check("rst_errs", {err_overflow, err_line, err_frame}, 0);
    check("rst_data", out_data, 0);
    nreset = 1'b1;
    tick(4);
    check("idle_state", dbg_state, ST_WAIT_VS);

    // clean frame
    capture_en = 1'b1;
    seed = 1;
    cam_frame(H, 1'b1, -1, "clean_drain");
    check("clean_count", frame_count, 1);
    check("clean_errs", {err_overflow, err_line, err_frame}, 0);

    // enable raised mid-frame: that frame ignored, next one captured
    capture_en = 1'b0;
    seed = 2;
    vsync = 1'b1;
    tick(3);
    cam_line(W, 0, 1'b0, W);
    capture_en = 1'b1;
    for (int y = 1; y < H; y++) cam_line(W, y, 1'b0, W);
    check("late_en_busy", busy, 0);
    vsync = 1'b0;
    tick(6);
    wait_drain("late_en_drain");
    check("late_en_count", frame_count, 1);
    seed = 3;
    cam_frame(H, 1'b1, -1, "after_en_drain");
    check("after_en_count", frame_count, 2);

    // row 1 has one extra pixel
    seed = 4;
    cam_frame(H, 1'b1, 1, "long_drain");
    check("long_err_line", err_line, 1);
    check("long_err_frame", err_frame, 0);
    check("long_count", frame_count, 2);
    pulse_clear();
    check("long_cleared", err_line, 0);

    // vsync falls one line early
    seed = 5;
    cam_frame(H - 1, 1'b1, -1, "short_drain");
    check("short_err_frame", err_frame, 1);
    check("short_err_line", err_line, 0);
    check("short_count", frame_count, 2);
    pulse_clear();
    check("short_cleared", {err_overflow, err_line, err_frame}, 0);

    // downstream stalls through line 0: 16 held, the rest dropped
    seed = 6;
    vsync = 1'b1;
    tick(3);
    out_ready = 1'b0;
    cam_line(W, 0, 1'b1, 16);
    tick(11);
    check("stall_valid", out_valid, 1);
    check("stall_head_x", out_x, 0);
    check("stall_ovf", err_overflow, 1);
    out_ready = 1'b1;
    tick(20);
    for (int y = 1; y < H; y++) cam_line(W, y, 1'b1, W);
    vsync = 1'b0;
    tick(6);
    wait_drain("stall_drain");
    check("stall_count", frame_count, 2);
    check("stall_line_frame", {err_line, err_frame}, 0);
    pulse_clear();
    check("stall_cleared", err_overflow, 0);

    // reset asserted mid-line, released mid-frame
    seed = 7;
    out_ready = 1'b0;
    vsync = 1'b1;
    tick(3);
    for (int x = 0; x < 10; x++) begin
      hsync = 1'b1;
      pixdata = pix_val(x, 0);
      tick(1);
    end
    nreset = 1'b0;
    tick(1);
    check("mrst_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_count", frame_count, 0);
    check("mrst_errs", {err_overflow, err_line, err_frame}, 0);
    check("mrst_fields", {out_data, out_x, out_y, out_sof, out_eof}, 0);
    tick(2);
    nreset = 1'b1;
    for (int x = 10; x < W; x++) begin
      pixdata = pix_val(x, 0);
      tick(1);
    end
    hsync = 1'b0;
    tick(4);
    out_ready = 1'b1;
    for (int y = 1; y < H; y++) cam_line(W, y, 1'b0, W);
    check("mrst_no_start", busy, 0);
    vsync = 1'b0;
    tick(6);
    wait_drain("mrst_drain");
    seed = 8;
    cam_frame(H, 1'b1, -1, "post_rst_drain");
    check("post_rst_count", frame_count, 1);
    check("post_rst_errs", {err_overflow, err_line, err_frame}, 0);
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
